// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes and FSM encoding for the iterative multiply/divide unit
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done request bus and HI/LO read-out for muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Works on operand magnitudes one bit per cycle, then applies sign correction in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 signed_op;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;
  logic [WIDTH:0]       rem_new;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_raw, rem_raw;
  logic [2*WIDTH-1:0]   prod_fix;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg     = signed_op && bus.a[WIDTH-1];
  assign b_neg     = signed_op && bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;

  // Multiply: multiplier sits in the low half and is shifted out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, quotient bits enter at the bottom.
  // A zero divisor always "subtracts", which yields an all-ones quotient and |a| as remainder.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
  assign rem_new  = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
  assign div_next = {rem_new[WIDTH-1:0], acc_q[WIDTH-2:0], rem_ge};

  assign quo_raw  = acc_q[WIDTH-1:0];
  assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix = qneg_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (!bus.op[2]) begin
            state_d  = S_RUN;
            cnt_d    = CW'(WIDTH);
            is_div_d = bus.op[1];
            if (bus.op[1]) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
              // Divide by zero keeps the all-ones quotient unsigned.
              qneg_d = (a_neg ^ b_neg) && (bus.b != '0);
              rneg_d = a_neg;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
              qneg_d = a_neg ^ b_neg;
              rneg_d = 1'b0;
            end
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = qneg_q ? -quo_raw : quo_raw;
            hi_d = rneg_q ? -rem_raw : rem_raw;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus32();
  muldiv_unit_if #(.WIDTH(8))  bus8();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(input int w, input logic st, input logic [2:0] o,
                     input logic [31:0] x, input logic [31:0] y, input logic fl);
    if (w == 32) begin
      bus32.start = st; bus32.op = o; bus32.a = x; bus32.b = y; bus32.flush = fl;
    end else begin
      bus8.start = st; bus8.op = o; bus8.a = x[7:0]; bus8.b = y[7:0]; bus8.flush = fl;
    end
  endtask

  function automatic logic [31:0] rd_busy(input int w);
    return (w == 32) ? {31'd0, bus32.busy} : {31'd0, bus8.busy};
  endfunction
  function automatic logic [31:0] rd_done(input int w);
    return (w == 32) ? {31'd0, bus32.done} : {31'd0, bus8.done};
  endfunction
  function automatic logic [31:0] rd_hi(input int w);
    return (w == 32) ? bus32.hi : {24'd0, bus8.hi};
  endfunction
  function automatic logic [31:0] rd_lo(input int w);
    return (w == 32) ? bus32.lo : {24'd0, bus8.lo};
  endfunction

  // Drive a request for one cycle; returns at the falling edge after the accepting edge.
  task automatic issue(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    drv(w, 1'b1, o, x, y, 1'b0);
    @(negedge clk);
    drv(w, 1'b0, o, x, y, 1'b0);
  endtask

  // Counts sampled busy cycles until done is seen; bounded.
  task automatic wait_done(input int w, output int lat, output int ok);
    lat = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (rd_done(w) != 0) begin
        ok = 1;
        break;
      end
      if (rd_busy(w) != 0) lat++;
      @(negedge clk);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values; HI/LO state carried by caller.
  task automatic model(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       inout logic [31:0] mhi, inout logic [31:0] mlo);
    logic [63:0] mask, ux, uy, p;
    longint sx, sy, q, r;
    mask = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & mask;
    uy = {32'd0, y} & mask;
    sx = ux[w-1] ? (longint'(ux) - longint'(64'd1 << w)) : longint'(ux);
    sy = uy[w-1] ? (longint'(uy) - longint'(64'd1 << w)) : longint'(uy);
    case (o)
      OP_MULT, OP_MULTU: begin
        p = (o == OP_MULT) ? 64'(sx * sy) : (ux * uy);
        mhi = 32'((p >> w) & mask);
        mlo = 32'(p & mask);
      end
      OP_DIV, OP_DIVU: begin
        if (uy == 64'd0) begin
          mlo = 32'(mask);
          mhi = 32'(ux);
        end else if (o == OP_DIV) begin
          q = sx / sy;
          r = sx % sy;
          mlo = 32'(64'(q) & mask);
          mhi = 32'(64'(r) & mask);
        end else begin
          mlo = 32'((ux / uy) & mask);
          mhi = 32'((ux % uy) & mask);
        end
      end
      OP_MTHI: mhi = 32'(ux);
      OP_MTLO: mlo = 32'(ux);
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'(64'd1 << (w - 1));
      2: return 32'(m);
      3: return 32'(m >> 1);
      default: return $urandom & 32'(m);
    endcase
  endfunction

  task automatic rand_run(input int w, input int n);
    logic [31:0] mhi, mlo, x, y;
    logic [2:0] o;
    int v, lat, ok;
    mhi = 32'd0;
    mlo = 32'd0;
    for (int i = 0; i < n; i++) begin
      v = int'($urandom_range(0, 11));
      o = (v < 8) ? 3'(v) : 3'(v - 8);
      x = pick(w);
      y = pick(w);
      model(w, o, x, y, mhi, mlo);
      issue(w, o, x, y);
      if (!o[2]) begin
        wait_done(w, lat, ok);
        check($sformatf("w%0d_rand%0d_done_seen", w, i), 32'(ok), 32'd1);
        check($sformatf("w%0d_rand%0d_latency", w, i), 32'(lat), 32'(w + 1));
      end else begin
        check($sformatf("w%0d_rand%0d_busy_mt", w, i), rd_busy(w), 32'd0);
      end
      check($sformatf("w%0d_rand%0d_op%0d_hi", w, i, o), rd_hi(w), mhi);
      check($sformatf("w%0d_rand%0d_op%0d_lo", w, i, o), rd_lo(w), mlo);
    end
  endtask

  initial begin
    int lat, ok, seen;

    vecs[0] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9] = '{OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

    drv(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drv(8,  1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", rd_busy(32), 32'd0);
    check("reset_done", rd_done(32), 32'd0);
    check("reset_hi", rd_hi(32), 32'd0);
    check("reset_lo", rd_lo(32), 32'd0);
    check("reset_hi_w8", rd_hi(8), 32'd0);

    // Each vector starts in the done cycle of the previous one.
    for (int i = 0; i < 10; i++) begin
      issue(32, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(32, lat, ok);
      check($sformatf("vec%0d_done_seen", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("vec%0d_hi", i), rd_hi(32), vecs[i].hi);
      check($sformatf("vec%0d_lo", i), rd_lo(32), vecs[i].lo);
    end
    @(negedge clk);
    check("done_one_cycle", rd_done(32), 32'd0);
    check("busy_after_done", rd_busy(32), 32'd0);

    issue(32, OP_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", rd_hi(32), 32'h1234);
    check("mthi_busy", rd_busy(32), 32'd0);
    check("mthi_done", rd_done(32), 32'd0);

    // MTLO while a divide is busy must be ignored.
    issue(32, OP_DIV, 32'd100, 32'd7);
    drv(32, 1'b1, OP_MTLO, 32'hDEADBEEF, 32'd0, 1'b0);
    @(negedge clk);
    drv(32, 1'b0, OP_MTLO, 32'hDEADBEEF, 32'd0, 1'b0);
    wait_done(32, lat, ok);
    check("div_busy_mtlo_done_seen", 32'(ok), 32'd1);
    check("div_busy_mtlo_lo", rd_lo(32), 32'd14);
    check("div_busy_mtlo_hi", rd_hi(32), 32'd2);
    @(negedge clk);
    check("div_busy_mtlo_lo_after", rd_lo(32), 32'd14);

    // Flush mid-multiply keeps the preloaded HI/LO.
    issue(32, OP_MTHI, 32'hAA, 32'd0);
    issue(32, OP_MTLO, 32'hBB, 32'd0);
    issue(32, OP_MULT, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    check("flush_busy_before", rd_busy(32), 32'd1);
    drv(32, 1'b0, OP_MULT, 32'd3, 32'd5, 1'b1);
    @(negedge clk);
    drv(32, 1'b0, OP_MULT, 32'd3, 32'd5, 1'b0);
    check("flush_busy_after", rd_busy(32), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd_done(32) != 0) seen++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_hi", rd_hi(32), 32'hAA);
    check("flush_lo", rd_lo(32), 32'hBB);

    // Flush in IDLE drops a coincident start.
    drv(32, 1'b1, OP_MULT, 32'd3, 32'd5, 1'b1);
    @(negedge clk);
    check("idle_flush_mult_busy", rd_busy(32), 32'd0);
    drv(32, 1'b1, OP_MTHI, 32'h999, 32'd0, 1'b1);
    @(negedge clk);
    drv(32, 1'b0, OP_MTHI, 32'h999, 32'd0, 1'b0);
    check("idle_flush_mthi_hi", rd_hi(32), 32'hAA);

    // Asynchronous reset in the middle of a divide.
    issue(32, OP_DIV, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", rd_busy(32), 32'd0);
    check("async_rst_done", rd_done(32), 32'd0);
    check("async_rst_hi", rd_hi(32), 32'd0);
    check("async_rst_lo", rd_lo(32), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", rd_busy(32), 32'd0);

    rand_run(8, 300);
    rand_run(32, 150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
